// File: rtl/clock_pkg.sv
// Shared definitions for the time-setting controller: state encoding,
// step operation type, field indexing helpers and default field limits.
package clock_pkg;

    localparam int DEF_NUM_FIELDS = 3;
    localparam int DEF_FIELD_W    = 6;

    // Hours, minutes, seconds maxima; field i sits at [i*FIELD_W +: FIELD_W].
    localparam logic [DEF_NUM_FIELDS*DEF_FIELD_W-1:0] DEF_FIELD_MAX = {6'd23, 6'd59, 6'd59};

    // State index 0 is NORMAL; index k+1 adjusts field k.
    localparam int ST_NORMAL = 0;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_INC,
        STEP_DEC
    } step_e;

    // Bits needed to encode NORMAL plus one adjust state per field.
    function automatic int state_width(input int num_fields);
        return $clog2(num_fields + 1);
    endfunction

    // Lowest bit of field idx inside a packed field vector.
    function automatic int field_lsb(input int idx, input int field_w);
        return idx * field_w;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Hold-to-auto-repeat timer for one key: after the level has been high for
// HOLD_TICKS ticks it emits a step, then one more every RPT_TICKS ticks.
module key_repeat #(
    parameter int HOLD_TICKS = 8,
    parameter int RPT_TICKS  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_en,
    input  logic level,
    input  logic enable,
    output logic repeat_pulse
);

    localparam int CW = $clog2(HOLD_TICKS + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
    // Reloading to HOLD-RPT after each step makes the next step land RPT ticks later.
    localparam logic [CW-1:0] RELOAD    = CW'(HOLD_TICKS - RPT_TICKS);

    logic [CW-1:0] hold_cnt;
    logic          active;

    assign active       = level & enable;
    assign repeat_pulse = active & tick_en & (hold_cnt == HOLD_LAST);

    // Count ticks while the key is held; drop to zero the moment it is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (!active) begin
            hold_cnt <= '0;
        end else if (tick_en) begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            hold_cnt <= repeat_pulse ? RELOAD : hold_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clock_adjust_ctrl.sv
// Time-setting controller: cycles through the adjustable fields on mode
// presses, steps the active field with wrap on inc/dec (including auto-repeat),
// returns to NORMAL after inactivity and drives the display blink mask.
module clock_adjust_ctrl
    import clock_pkg::*;
#(
    parameter int                                NUM_FIELDS  = DEF_NUM_FIELDS,
    parameter int                                FIELD_W     = DEF_FIELD_W,
    parameter logic [NUM_FIELDS*FIELD_W-1:0]     FIELD_MAX   = DEF_FIELD_MAX,
    parameter int                                HOLD_TICKS  = 8,
    parameter int                                RPT_TICKS   = 2,
    parameter int                                TMO_TICKS   = 1000,
    parameter int                                BLINK_TICKS = 50
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick_en,
    input  logic                          key_mode_pulse,
    input  logic                          key_inc_pulse,
    input  logic                          key_dec_pulse,
    input  logic                          key_inc_level,
    input  logic                          key_dec_level,
    input  logic [NUM_FIELDS*FIELD_W-1:0] time_in,
    output logic                          time_count_en,
    output logic                          load_en,
    output logic [NUM_FIELDS*FIELD_W-1:0] time_out,
    output logic [NUM_FIELDS-1:0]         adj_field,
    output logic [NUM_FIELDS-1:0]         blank_mask
);

    localparam int SW = state_width(NUM_FIELDS);
    localparam int TW = $clog2(TMO_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    localparam logic [SW-1:0] S_NORMAL   = SW'(ST_NORMAL);
    localparam logic [SW-1:0] S_TOP      = SW'(NUM_FIELDS);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TMO_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [SW-1:0]                  state;
    logic [SW-1:0]                  state_nx;
    logic [TW-1:0]                  tmo_cnt;
    logic [BW-1:0]                  blink_cnt;
    logic                           phase;
    logic                           in_adj;
    logic                           inc_rpt;
    logic                           dec_rpt;
    logic                           inc_req;
    logic                           dec_req;
    logic                           activity;
    logic                           tmo_hit;
    step_e                          op;
    logic [NUM_FIELDS*FIELD_W-1:0]  step_val;

    // Wrap-around step of a single field value.
    function automatic logic [FIELD_W-1:0] step_field(
        input logic [FIELD_W-1:0] v,
        input logic [FIELD_W-1:0] mx,
        input step_e              how
    );
        case (how)
            STEP_INC: return (v == mx) ? '0 : v + 1'b1;
            STEP_DEC: return (v == '0) ? mx : v - 1'b1;
            default:  return v;
        endcase
    endfunction

    assign in_adj        = (state != S_NORMAL);
    assign time_count_en = ~in_adj;

    key_repeat #(
        .HOLD_TICKS (HOLD_TICKS),
        .RPT_TICKS  (RPT_TICKS)
    ) u_inc_repeat (
        .clk          (clk),
        .rst          (rst),
        .tick_en      (tick_en),
        .level        (key_inc_level),
        .enable       (in_adj),
        .repeat_pulse (inc_rpt)
    );

    key_repeat #(
        .HOLD_TICKS (HOLD_TICKS),
        .RPT_TICKS  (RPT_TICKS)
    ) u_dec_repeat (
        .clk          (clk),
        .rst          (rst),
        .tick_en      (tick_en),
        .level        (key_dec_level),
        .enable       (in_adj),
        .repeat_pulse (dec_rpt)
    );

    assign inc_req  = key_inc_pulse | inc_rpt;
    assign dec_req  = key_dec_pulse | dec_rpt;
    assign activity = key_mode_pulse | key_inc_pulse | key_dec_pulse
                    | key_inc_level | key_dec_level;
    assign tmo_hit  = in_adj & tick_en & ~activity & (tmo_cnt == TMO_LAST);

    // Decode the one-hot active field from the state index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        adj_field = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (state == SW'(i + 1)) adj_field[i] = 1'b1;
        end
    end

    assign blank_mask = (key_inc_level | key_dec_level) ? '0
                                                        : (adj_field & {NUM_FIELDS{phase}});

    // Resolve the step request: mode wins, and a simultaneous inc+dec cancels.
    always_comb begin
        op = STEP_NONE;
        if (in_adj && !key_mode_pulse && (inc_req ^ dec_req)) begin
            op = inc_req ? STEP_INC : STEP_DEC;
        end
    end

    // Next state: mode walks NORMAL->top field->...->field 0->NORMAL; timeout exits.
    always_comb begin
        state_nx = state;
        if (key_mode_pulse) begin
            state_nx = (state == S_NORMAL) ? S_TOP : state - 1'b1;
        end else if (tmo_hit) begin
            state_nx = S_NORMAL;
        end
    end

    // Step only the active field; all others pass through from time_in.
    always_comb begin
        step_val = time_in;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (adj_field[i]) begin
                step_val[field_lsb(i, FIELD_W) +: FIELD_W] =
                    step_field(time_in[field_lsb(i, FIELD_W) +: FIELD_W],
                               FIELD_MAX[field_lsb(i, FIELD_W) +: FIELD_W], op);
            end
        end
    end

    // State register, registered load strobe, timeout and blink timers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_NORMAL;
            load_en   <= 1'b0;
            time_out  <= '0;
            tmo_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            state   <= state_nx;
            load_en <= (op != STEP_NONE);
            if (op != STEP_NONE) time_out <= step_val;

            if (!in_adj || activity) begin
                tmo_cnt <= '0;
            end else if (tick_en) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            // Blink restarts from the visible phase whenever the active field changes.
            if (!in_adj || (state_nx != state)) begin
                blink_cnt <= '0;
                phase     <= 1'b0;
            end else if (tick_en) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// Self-checking bench for clock_adjust_ctrl: directed scenarios followed by
// random key traffic, all compared cycle by cycle against a behavioural model.
module tb_clock_adjust_ctrl;

    localparam int NF    = 3;
    localparam int FW    = 6;
    localparam int HOLD  = 8;
    localparam int RPT   = 2;
    localparam int TMO   = 1000;
    localparam int BLINK = 50;
    localparam logic [NF*FW-1:0] FMAX = {6'd23, 6'd59, 6'd59};

    logic           clk = 1'b0;
    logic           rst;
    logic           tick_en;
    logic           key_mode_pulse;
    logic           key_inc_pulse;
    logic           key_dec_pulse;
    logic           key_inc_level;
    logic           key_dec_level;
    logic [NF*FW-1:0] time_in;
    logic           time_count_en;
    logic           load_en;
    logic [NF*FW-1:0] time_out;
    logic [NF-1:0]  adj_field;
    logic [NF-1:0]  blank_mask;

    clock_adjust_ctrl #(
        .NUM_FIELDS  (NF),
        .FIELD_W     (FW),
        .FIELD_MAX   (FMAX),
        .HOLD_TICKS  (HOLD),
        .RPT_TICKS   (RPT),
        .TMO_TICKS   (TMO),
        .BLINK_TICKS (BLINK)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tick_en        (tick_en),
        .key_mode_pulse (key_mode_pulse),
        .key_inc_pulse  (key_inc_pulse),
        .key_dec_pulse  (key_dec_pulse),
        .key_inc_level  (key_inc_level),
        .key_dec_level  (key_dec_level),
        .time_in        (time_in),
        .time_count_en  (time_count_en),
        .load_en        (load_en),
        .time_out       (time_out),
        .adj_field      (adj_field),
        .blank_mask     (blank_mask)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: field being adjusted (-1 = normal), ticks held per key,
    // ticks idle, ticks since entering the field, and expected load outputs.
    int               max_v [NF];
    int               m_field;
    int               m_hold_inc;
    int               m_hold_dec;
    int               m_idle;
    int               m_blink;
    logic             m_load;
    logic [NF*FW-1:0] m_tout;

    task automatic model_reset();
        m_field    = -1;
        m_hold_inc = 0;
        m_hold_dec = 0;
        m_idle     = 0;
        m_blink    = 0;
        m_load     = 1'b0;
        m_tout     = '0;
    endtask

    function automatic logic [NF-1:0] exp_adj();
        logic [NF-1:0] r;
        r = '0;
        if (m_field >= 0) r[m_field] = 1'b1;
        return r;
    endfunction

    function automatic logic [NF-1:0] exp_blank();
        if (key_inc_level || key_dec_level) return '0;
        if (((m_blink / BLINK) % 2) == 1) return exp_adj();
        return '0;
    endfunction

    function automatic bit repeat_due(input int held_after);
        return (held_after >= HOLD) && (((held_after - HOLD) % RPT) == 0);
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit adj, r_inc, r_dec, inc, dec, act, tmo, stp;
        int nf, tk, v;
        adj   = (m_field >= 0);
        tk    = tick_en ? 1 : 0;
        r_inc = adj && key_inc_level && tick_en && repeat_due(m_hold_inc + 1);
        r_dec = adj && key_dec_level && tick_en && repeat_due(m_hold_dec + 1);
        m_hold_inc = (adj && key_inc_level) ? m_hold_inc + tk : 0;
        m_hold_dec = (adj && key_dec_level) ? m_hold_dec + tk : 0;
        inc = key_inc_pulse || r_inc;
        dec = key_dec_pulse || r_dec;
        act = key_mode_pulse || key_inc_pulse || key_dec_pulse || key_inc_level || key_dec_level;
        tmo = adj && !act && tick_en && (m_idle + 1 >= TMO);
        stp = adj && !key_mode_pulse && (inc != dec);
        m_load = stp;
        if (stp) begin
            m_tout = time_in;
            v = int'(time_in[m_field*FW +: FW]);
            if (inc) v = (v == max_v[m_field]) ? 0 : v + 1;
            else     v = (v == 0) ? max_v[m_field] : v - 1;
            m_tout[m_field*FW +: FW] = FW'(v);
        end
        if (key_mode_pulse) nf = (m_field < 0) ? NF - 1 : m_field - 1;
        else if (tmo)       nf = -1;
        else                nf = m_field;
        m_idle  = (!adj || act) ? 0 : m_idle + tk;
        m_blink = (!adj || nf != m_field) ? 0 : m_blink + tk;
        m_field = nf;
    endtask

    task automatic check_outputs();
        check("count_en",  32'(time_count_en), 32'(m_field < 0));
        check("adj_field", 32'(adj_field),     32'(exp_adj()));
        check("load_en",   32'(load_en),       32'(m_load));
        check("time_out",  32'(time_out),      32'(m_tout));
        check("blank",     32'(blank_mask),    32'(exp_blank()));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_count_en"}, 32'(time_count_en), 32'd1);
        check({tag, "_adj"},      32'(adj_field),     32'd0);
        check({tag, "_load"},     32'(load_en),       32'd0);
        check({tag, "_tout"},     32'(time_out),      32'd0);
        check({tag, "_blank"},    32'(blank_mask),    32'd0);
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic step_cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n, input logic tk);
        for (int i = 0; i < n; i++) begin
            tick_en = tk;
            step_cycle();
        end
    endtask

    task automatic pulse(input logic m, input logic i, input logic d);
        key_mode_pulse = m;
        key_inc_pulse  = i;
        key_dec_pulse  = d;
        step_cycle();
        key_mode_pulse = 1'b0;
        key_inc_pulse  = 1'b0;
        key_dec_pulse  = 1'b0;
    endtask

    int loads;

    initial begin
        logic [NF*FW-1:0] fm;
        fm = FMAX;
        for (int i = 0; i < NF; i++) max_v[i] = int'(fm[i*FW +: FW]);

        rst = 1'b1;
        tick_en = 1'b1;
        key_mode_pulse = 1'b0; key_inc_pulse = 1'b0; key_dec_pulse = 1'b0;
        key_inc_level = 1'b0;  key_dec_level = 1'b0;
        time_in = {6'd23, 6'd0, 6'd30};
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        run(2, 1'b1);

        // Mode walk through every field and back to normal.
        pulse(1, 0, 0); check("t1_adj2", 32'(adj_field), 32'b100);
        pulse(1, 0, 0); check("t1_adj1", 32'(adj_field), 32'b010);
        pulse(1, 0, 0); check("t1_adj0", 32'(adj_field), 32'b001);
        pulse(1, 0, 0); check("t1_normal", 32'(adj_field), 32'b000);
        check("t1_count_en", 32'(time_count_en), 32'd1);

        // Hours wrap up, minutes wrap down.
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        check("t2_load", 32'(load_en), 32'd1);
        check("t2_hours_wrap", 32'(time_out), 32'({6'd0, 6'd0, 6'd30}));
        run(1, 1'b1);
        check("t2_load_once", 32'(load_en), 32'd0);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        check("t2_min_wrap", 32'(time_out), 32'({6'd23, 6'd59, 6'd30}));

        // Hold inc for 14 ticks in ADJ_1: press load plus repeats at 8,10,12,14.
        loads = 0;
        tick_en = 1'b1;
        key_inc_pulse = 1'b1; key_inc_level = 1'b1;
        step_cycle();
        loads += int'(load_en);
        key_inc_pulse = 1'b0;
        repeat (13) begin step_cycle(); loads += int'(load_en); end
        key_inc_level = 1'b0;
        repeat (6) begin step_cycle(); loads += int'(load_en); end
        check("t3_loads", 32'(loads), 32'd5);

        // Conflicting inc+dec is dropped; mode beats a coincident step.
        pulse(0, 1, 1);
        check("t4_both_drop", 32'(load_en), 32'd0);
        pulse(1, 0, 0); pulse(1, 0, 0); pulse(1, 0, 0);
        check("t4_at_adj2", 32'(adj_field), 32'b100);
        pulse(1, 1, 0);
        check("t4_mode_wins_adj", 32'(adj_field), 32'b010);
        check("t4_mode_wins_load", 32'(load_en), 32'd0);

        // Inactivity timeout, restarted by a key just before it expires.
        pulse(1, 0, 0);
        run(998, 1'b1);
        key_inc_level = 1'b1;
        step_cycle();
        key_inc_level = 1'b0;
        run(999, 1'b1);
        check("t5_still_adj0", 32'(adj_field), 32'b001);
        run(1, 1'b1);
        check("t5_timeout_cnt_en", 32'(time_count_en), 32'd1);
        check("t5_timeout_adj", 32'(adj_field), 32'd0);

        // Asynchronous reset while inc is held in ADJ_1.
        pulse(1, 0, 0); pulse(1, 0, 0);
        key_inc_pulse = 1'b1; key_inc_level = 1'b1;
        step_cycle();
        key_inc_pulse = 1'b0;
        run(9, 1'b1);
        #2 rst = 1'b1;
        #1 check_reset("t6_async");
        model_reset();
        repeat (2) @(negedge clk);
        check_reset("t6_held");
        rst = 1'b0;
        loads = 0;
        repeat (12) begin step_cycle(); loads += int'(load_en); end
        check("t6_no_load", 32'(loads), 32'd0);
        key_inc_level = 1'b0;
        run(2, 1'b1);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            tick_en        = ($urandom_range(0, 1) == 0);
            key_mode_pulse = ($urandom_range(0, 29) == 0);
            key_inc_pulse  = ($urandom_range(0, 9) == 0);
            key_dec_pulse  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) key_inc_level = ~key_inc_level;
            if ($urandom_range(0, 24) == 0) key_dec_level = ~key_dec_level;
            time_in = {6'($urandom_range(0, 23)), 6'($urandom_range(0, 59)), 6'($urandom_range(0, 59))};
            step_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
